// File: rtl/id_ex_shift_stage_pkg.sv
// Shared encodings and default widths for the ID/EX shift stage.
package id_ex_shift_stage_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned RW_DEF = 3;
  localparam int unsigned CW_DEF = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MWB = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/id_ex_shift_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats register-file data.
module fwd_mux
  import id_ex_shift_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_wr,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] data,
  output logic          hit
);

  fwd_sel_e sel;

  // Pick the youngest matching producer for this register index.
  always_comb begin
    sel = FWD_RF;
    if (exm_wr && (exm_rd == idx))
      sel = FWD_EXM;
    else if (mwb_wr && (mwb_rd == idx))
      sel = FWD_MWB;

    data = rf_data;
    unique case (sel)
      FWD_EXM: data = exm_data;
      FWD_MWB: data = mwb_data;
      default: data = rf_data;
    endcase
    hit = (sel != FWD_RF);
  end

endmodule

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register feeding the execute-stage shifter, with operand
// forwarding on capture and writeback snooping while stalled.
module id_ex_shift_stage
  import id_ex_shift_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [1:0]    id_op,
  input  logic          id_use_imm,
  input  logic [CW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_wr,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] sh_in,
  output logic [CW-1:0] sh_cnt,
  output logic [1:0]    sh_op,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic [7:0]    fwd_hits
);

  stage_state_e state_q, state_d;

  logic [RW-1:0] rs_q, rt_q;
  logic          use_imm_q;

  logic [DW-1:0] cap_rs, cap_rt, snp_rs, snp_rt;
  logic          cap_rs_hit, cap_rt_hit, snp_rs_hit, snp_rt_hit;
  logic [CW-1:0] cap_cnt, snp_cnt;
  logic [1:0]    hit_inc;
  logic [8:0]    hits_sum;
  logic [7:0]    hits_next;
  logic [DW-1:0] cnt_ext;

  logic unused_rt_hi;
  logic unused_snp_hit;

  // Capture-path forwarding for the incoming instruction.
  fwd_mux #(.DW(DW), .RW(RW)) u_cap_rs (
    .idx(id_rs), .rf_data(id_rs_data),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .data(cap_rs), .hit(cap_rs_hit)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_cap_rt (
    .idx(id_rt), .rf_data(id_rt_data),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .data(cap_rt), .hit(cap_rt_hit)
  );

  // Snoop-path muxes fall back to the held value, so no-hit means no change.
  assign cnt_ext = {{(DW-CW){1'b0}}, sh_cnt};

  fwd_mux #(.DW(DW), .RW(RW)) u_snp_rs (
    .idx(rs_q), .rf_data(sh_in),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .data(snp_rs), .hit(snp_rs_hit)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_snp_rt (
    .idx(rt_q), .rf_data(cnt_ext),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .data(snp_rt), .hit(snp_rt_hit)
  );

  // Count source selection and saturating forward-hit accumulation.
  always_comb begin
    cap_cnt   = id_use_imm ? id_imm : cap_rt[CW-1:0];
    snp_cnt   = use_imm_q ? sh_cnt : snp_rt[CW-1:0];
    hit_inc   = {1'b0, cap_rs_hit} + {1'b0, (cap_rt_hit && !id_use_imm)};
    hits_sum  = {1'b0, fwd_hits} + {7'd0, hit_inc};
    hits_next = hits_sum[8] ? 8'hFF : hits_sum[7:0];
  end

  // Shift-count bits above CW and the snoop hit flags are intentionally unused.
  assign unused_rt_hi   = ^{cap_rt[DW-1:CW], snp_rt[DW-1:CW]};
  assign unused_snp_hit = snp_rs_hit ^ snp_rt_hit;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next state: flush beats stall, stall holds, else follow id_valid.
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = ST_EMPTY;
    else if (!stall)
      state_d = id_valid ? ST_FULL : ST_EMPTY;
  end

  assign ex_valid = (state_q == ST_FULL);

  // Datapath registers: flush keeps data, stall snoops, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_in     <= '0;
      sh_cnt    <= '0;
      sh_op     <= '0;
      ex_rd     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
      fwd_hits  <= '0;
    end else if (flush) begin
      sh_in <= sh_in;
    end else if (stall) begin
      sh_in  <= snp_rs;
      sh_cnt <= snp_cnt;
    end else begin
      sh_in     <= cap_rs;
      sh_cnt    <= cap_cnt;
      sh_op     <= id_op;
      ex_rd     <= id_rd;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      use_imm_q <= id_use_imm;
      if (id_valid)
        fwd_hits <= hits_next;
    end
  end

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Directed self-checking bench for id_ex_shift_stage.
module tb_id_ex_shift_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_op;
  logic        id_use_imm;
  logic [3:0]  id_imm;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data;
  logic        exm_wr;
  logic [2:0]  exm_rd;
  logic [15:0] exm_data;
  logic        mwb_wr;
  logic [2:0]  mwb_rd;
  logic [15:0] mwb_data;
  logic        stall, flush;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic        ex_valid;
  logic [2:0]  ex_rd;
  logic [7:0]  fwd_hits;

  int tests_run;
  int tests_failed;

  id_ex_shift_stage #(.DW(16), .RW(3), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_op(id_op), .id_use_imm(id_use_imm), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .stall(stall), .flush(flush),
    .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .fwd_hits(fwd_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_op = 2'b00; id_use_imm = 0; id_imm = 4'd0;
    id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0;
    id_rs_data = 16'h0; id_rt_data = 16'h0;
    exm_wr = 0; exm_rd = 3'd0; exm_data = 16'h0;
    mwb_wr = 0; mwb_rd = 3'd0; mwb_data = 16'h0;
    stall = 0; flush = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {15'd0, ex_valid}, 16'h0);
    chk({tag, ".in"},    sh_in, 16'h0);
    chk({tag, ".cnt"},   {12'd0, sh_cnt}, 16'h0);
    chk({tag, ".op"},    {14'd0, sh_op}, 16'h0);
    chk({tag, ".rd"},    {13'd0, ex_rd}, 16'h0);
    chk({tag, ".hits"},  {8'd0, fwd_hits}, 16'h0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 0;

    // Plain capture with immediate count.
    id_valid = 1; id_op = 2'b01; id_rs = 3'd1; id_rs_data = 16'h00F0;
    id_use_imm = 1; id_imm = 4'd4; id_rd = 3'd6;
    tick();
    chk("cap.in",    sh_in, 16'h00F0);
    chk("cap.cnt",   {12'd0, sh_cnt}, 16'd4);
    chk("cap.op",    {14'd0, sh_op}, 16'd1);
    chk("cap.valid", {15'd0, ex_valid}, 16'd1);
    chk("cap.rd",    {13'd0, ex_rd}, 16'd6);
    chk("cap.hits",  {8'd0, fwd_hits}, 16'd0);

    // Asynchronous reset mid-cycle while the stage is full.
    #1 rst = 1;
    #1;
    chk_all_zero("async_rst");
    #1 rst = 0;

    // Both buses match Rs and Rt: EX/MEM wins, count from register path.
    idle_inputs();
    id_valid = 1; id_op = 2'b10; id_rs = 3'd3; id_rt = 3'd3; id_rd = 3'd5;
    id_rs_data = 16'h1234; id_rt_data = 16'h0007; id_use_imm = 0;
    exm_wr = 1; exm_rd = 3'd3; exm_data = 16'hAAAA;
    mwb_wr = 1; mwb_rd = 3'd3; mwb_data = 16'h5555;
    tick();
    chk("dual.in",    sh_in, 16'hAAAA);
    chk("dual.cnt",   {12'd0, sh_cnt}, 16'hA);
    chk("dual.op",    {14'd0, sh_op}, 16'd2);
    chk("dual.rd",    {13'd0, ex_rd}, 16'd5);
    chk("dual.hits",  {8'd0, fwd_hits}, 16'd2);

    // MEM/WB-only match on Rt; upper Rt bits dropped from the count.
    idle_inputs();
    id_valid = 1; id_rs = 3'd4; id_rt = 3'd5; id_rs_data = 16'h8001;
    exm_wr = 1; exm_rd = 3'd6; exm_data = 16'h7777;
    mwb_wr = 1; mwb_rd = 3'd5; mwb_data = 16'hFFF3;
    tick();
    chk("mwb.in",   sh_in, 16'h8001);
    chk("mwb.cnt",  {12'd0, sh_cnt}, 16'd3);
    chk("mwb.hits", {8'd0, fwd_hits}, 16'd3);

    // Register 0 forwards; immediate count means Rt hit is not counted.
    idle_inputs();
    id_valid = 1; id_rs = 3'd0; id_rt = 3'd0; id_use_imm = 1; id_imm = 4'd9;
    exm_wr = 1; exm_rd = 3'd0; exm_data = 16'h0F0F;
    tick();
    chk("r0.in",   sh_in, 16'h0F0F);
    chk("r0.cnt",  {12'd0, sh_cnt}, 16'd9);
    chk("r0.hits", {8'd0, fwd_hits}, 16'd4);

    // Capture with id_valid=0 empties the stage and counts no hits.
    idle_inputs();
    id_rs = 3'd2; exm_wr = 1; exm_rd = 3'd2; exm_data = 16'h1111;
    tick();
    chk("bubble.valid", {15'd0, ex_valid}, 16'd0);
    chk("bubble.hits",  {8'd0, fwd_hits}, 16'd4);

    // Stall snoop: held Rs and register-sourced Rt refresh from the buses.
    idle_inputs();
    id_valid = 1; id_op = 2'b11; id_rs = 3'd2; id_rs_data = 16'h1111;
    id_rt = 3'd1; id_rt_data = 16'h0002; id_rd = 3'd7;
    tick();
    chk("pre.in",  sh_in, 16'h1111);
    chk("pre.cnt", {12'd0, sh_cnt}, 16'd2);
    idle_inputs();
    stall = 1; id_valid = 1; id_op = 2'b00; id_rs = 3'd4; id_rs_data = 16'hDEAD;
    mwb_wr = 1; mwb_rd = 3'd2; mwb_data = 16'hBEEF;
    exm_wr = 1; exm_rd = 3'd1; exm_data = 16'h000C;
    tick();
    chk("snoop.in",    sh_in, 16'hBEEF);
    chk("snoop.cnt",   {12'd0, sh_cnt}, 16'hC);
    chk("snoop.valid", {15'd0, ex_valid}, 16'd1);
    chk("snoop.op",    {14'd0, sh_op}, 16'd3);
    chk("snoop.rd",    {13'd0, ex_rd}, 16'd7);
    chk("snoop.hits",  {8'd0, fwd_hits}, 16'd4);

    // Flush beats stall, then a normal capture follows.
    idle_inputs();
    stall = 1; flush = 1; id_valid = 1;
    tick();
    chk("flush_stall.valid", {15'd0, ex_valid}, 16'd0);
    idle_inputs();
    id_valid = 1; id_op = 2'b01; id_rs = 3'd3; id_rs_data = 16'h0042;
    id_use_imm = 1; id_imm = 4'd1;
    tick();
    chk("after_flush.valid", {15'd0, ex_valid}, 16'd1);
    chk("after_flush.in",    sh_in, 16'h0042);
    chk("after_flush.op",    {14'd0, sh_op}, 16'd1);

    // Flush alone squashes a valid incoming instruction.
    flush = 1;
    tick();
    chk("flush.valid", {15'd0, ex_valid}, 16'd0);
    chk("flush.hits",  {8'd0, fwd_hits}, 16'd4);

    // Saturation: 300 single-hit captures starting from 4.
    idle_inputs();
    id_valid = 1; id_rs = 3'd1; id_use_imm = 1;
    exm_wr = 1; exm_rd = 3'd1; exm_data = 16'h0001;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("sat.mid", {8'd0, fwd_hits}, 16'd104);
    end
    chk("sat.end", {8'd0, fwd_hits}, 16'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
